// File: rtl/tc_pkg.sv
// Shared types and frame-field layout for the thermocouple scan scheduler.
// The decoder and any future single-channel reader import these definitions.
package tc_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CAPTURE,
    S_NEXT
  } tc_scan_state_t;

  localparam int TC_MSB      = 31;
  localparam int TC_LSB      = 18;
  localparam int JT_MSB      = 15;
  localparam int JT_LSB      = 4;
  localparam int FLT_BIT     = 16;
  localparam int FLT_LOW_MSB = 2;

  localparam int TC_W  = 14;
  localparam int JT_W  = 12;
  localparam int FLT_W = 4;

  typedef struct packed {
    logic [TC_W-1:0]  tc;
    logic [JT_W-1:0]  jt;
    logic [FLT_W-1:0] flt;
  } tc_fields_t;

endpackage

// File: rtl/tc_frame_decode.sv
// Combinational split of a 32-bit converter frame into thermocouple,
// junction and fault fields.
module tc_frame_decode
  import tc_pkg::*;
(
  input  logic [31:0] i_frame,
  output tc_fields_t  o_fields
);

  assign o_fields.tc  = i_frame[TC_MSB:TC_LSB];
  assign o_fields.jt  = i_frame[JT_MSB:JT_LSB];
  assign o_fields.flt = {i_frame[FLT_BIT], i_frame[FLT_LOW_MSB:0]};

endmodule

// File: rtl/tc_spi_scan_scheduler.sv
// Periodic round-robin scan of NCH converter chips over one shared SPI master,
// emitting one tagged, decoded sample (or a timeout pulse) per channel.
module tc_spi_scan_scheduler
  import tc_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CH_BITS = 2,
  parameter int PERIOD  = 30,
  parameter int TIMEOUT = 8,
  parameter int CBITS   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               spi_busy,
  input  logic [31:0]        spi_rx_data,
  output logic               spi_start,
  output logic [CH_BITS-1:0] chan_sel,
  output logic               sample_valid,
  output logic [CH_BITS-1:0] sample_chan,
  output logic [TC_W-1:0]    tc_temp,
  output logic [JT_W-1:0]    junction_temp,
  output logic [FLT_W-1:0]   fault_bits,
  output logic               timeout_err,
  output logic               scan_done
);

  localparam logic [CBITS-1:0]   PERIOD_M1  = CBITS'(PERIOD - 1);
  localparam logic [CBITS-1:0]   TIMEOUT_M1 = CBITS'(TIMEOUT - 1);
  localparam logic [CH_BITS-1:0] LAST_CH    = CH_BITS'(NCH - 1);

  tc_scan_state_t     r_state, w_state_nx;
  logic [CBITS-1:0]   r_cnt, w_cnt_nx;
  logic [CH_BITS-1:0] r_chan_sel, w_chan_nx;
  logic               w_timeout, w_last_done, w_capture;
  tc_fields_t         w_fields, r_fields;
  logic [CH_BITS-1:0] r_sample_chan;
  logic               r_sample_valid, r_timeout_err, r_scan_done;

  tc_frame_decode u_decode (
    .i_frame  (spi_rx_data),
    .o_fields (w_fields)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_chan_nx   = r_chan_sel;
    w_timeout   = 1'b0;
    w_last_done = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (!enable) begin
          w_cnt_nx = '0;
        end else if (r_cnt == PERIOD_M1) begin
          w_state_nx = S_START;
          w_cnt_nx   = '0;
          w_chan_nx  = '0;
        end else begin
          w_cnt_nx = r_cnt + CBITS'(1);
        end
      end
      S_START: begin
        w_state_nx = S_WAIT_BUSY;
        w_cnt_nx   = '0;
      end
      S_WAIT_BUSY: begin
        if (spi_busy) begin
          w_state_nx = S_WAIT_DONE;
          w_cnt_nx   = '0;
        end else if (r_cnt == TIMEOUT_M1) begin
          w_state_nx = S_NEXT;
          w_cnt_nx   = '0;
          w_timeout  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + CBITS'(1);
        end
      end
      // The master guarantees completion once busy was seen, so no timeout here.
      S_WAIT_DONE: begin
        if (!spi_busy) w_state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture  = 1'b1;
        w_state_nx = S_NEXT;
      end
      S_NEXT: begin
        if (r_chan_sel == LAST_CH) begin
          w_chan_nx   = '0;
          w_last_done = 1'b1;
          w_state_nx  = S_WAIT;
          w_cnt_nx    = '0;
        end else begin
          w_chan_nx  = r_chan_sel + CH_BITS'(1);
          w_state_nx = S_START;
        end
      end
      default: w_state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_state        <= S_WAIT;
      r_cnt          <= '0;
      r_chan_sel     <= '0;
      r_fields       <= '0;
      r_sample_chan  <= '0;
      r_sample_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_scan_done    <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_chan_sel     <= w_chan_nx;
      r_sample_valid <= w_capture;
      r_timeout_err  <= w_timeout;
      r_scan_done    <= w_last_done;
      if (w_capture) begin
        r_fields      <= w_fields;
        r_sample_chan <= r_chan_sel;
      end
    end
  end

  assign spi_start     = (r_state == S_START);
  assign chan_sel      = r_chan_sel;
  assign sample_valid  = r_sample_valid;
  assign sample_chan   = r_sample_chan;
  assign tc_temp       = r_fields.tc;
  assign junction_temp = r_fields.jt;
  assign fault_bits    = r_fields.flt;
  assign timeout_err   = r_timeout_err;
  assign scan_done     = r_scan_done;

endmodule

// File: tb/tb_tc_spi_scan_scheduler.sv
// Self-checking bench: an SPI-master responder, an event monitor and a
// per-scan scoreboard built from the channel response plan.
module tb_tc_spi_scan_scheduler;

  localparam int NCH = 4, CH_BITS = 2, PERIOD = 30, TIMEOUT = 8, CBITS = 6;

  logic clk = 1'b0;
  logic rst, enable, spi_busy;
  logic [31:0] spi_rx_data;
  logic spi_start, sample_valid, timeout_err, scan_done;
  logic [CH_BITS-1:0] chan_sel, sample_chan;
  logic [13:0] tc_temp;
  logic [11:0] junction_temp;
  logic [3:0]  fault_bits;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  tc_spi_scan_scheduler #(
    .NCH(NCH), .CH_BITS(CH_BITS), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .CBITS(CBITS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .spi_busy(spi_busy), .spi_rx_data(spi_rx_data),
    .spi_start(spi_start), .chan_sel(chan_sel), .sample_valid(sample_valid),
    .sample_chan(sample_chan), .tc_temp(tc_temp), .junction_temp(junction_temp),
    .fault_bits(fault_bits), .timeout_err(timeout_err), .scan_done(scan_done)
  );

  typedef struct {
    int          chan;
    logic [13:0] tc;
    logic [11:0] jt;
    logic [3:0]  flt;
    int          stamp;
  } ev_t;

  typedef struct {
    logic [31:0] frame;
    logic [13:0] tc;
    logic [11:0] jt;
    logic [3:0]  flt;
  } vec_t;

  ev_t q_start[$], q_samp[$], q_tmo[$], q_done[$];
  int b_start, b_samp, b_tmo, b_done;
  int prev_done_stamp;

  bit          cfg_resp[NCH];
  int          cfg_delay[NCH];
  int          cfg_hold[NCH];
  logic [31:0] cfg_frame[NCH];
  bit          pre_busy = 1'b0;

  logic [13:0] m_tc;
  logic [11:0] m_jt;
  logic [3:0]  m_flt;

  int checks = 0;
  int errors = 0;

  function automatic ev_t mk(input int ch);
    ev_t e;
    e.chan  = ch;
    e.tc    = tc_temp;
    e.jt    = junction_temp;
    e.flt   = fault_bits;
    e.stamp = cyc;
    return e;
  endfunction

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (spi_start)    q_start.push_back(mk(int'(chan_sel)));
      if (sample_valid) q_samp.push_back(mk(int'(sample_chan)));
      if (timeout_err)  q_tmo.push_back(mk(int'(chan_sel)));
      if (scan_done)    q_done.push_back(mk(int'(chan_sel)));
    end
  end

  // SPI master model: busy rises cfg_delay cycles after the start request, stays high cfg_hold cycles.
  initial begin
    int ch;
    spi_busy    = 1'b0;
    spi_rx_data = '0;
    forever begin
      @(negedge clk);
      if (spi_start && !rst) begin
        ch = int'(chan_sel);
        if (cfg_resp[ch]) begin
          repeat (cfg_delay[ch]) @(negedge clk);
          spi_busy = 1'b1;
          repeat (cfg_hold[ch]) @(negedge clk);
          spi_busy    = 1'b0;
          spi_rx_data = cfg_frame[ch];
        end
      end else begin
        spi_busy = pre_busy;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mark();
    b_start = q_start.size();
    b_samp  = q_samp.size();
    b_tmo   = q_tmo.size();
    b_done  = q_done.size();
  endtask

  task automatic plan(input bit resp, input int dly, input int hold, input logic [31:0] frame);
    for (int c = 0; c < NCH; c++) begin
      cfg_resp[c]  = resp;
      cfg_delay[c] = dly;
      cfg_hold[c]  = hold;
      cfg_frame[c] = frame;
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (q_done.size() == b_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q_done.size() == b_done) check({tag, " scan_done wait"}, 32'd0, 32'd1);
  endtask

  task automatic wait_first_start(input string tag, input int en_stamp);
    int n = 0;
    while (q_start.size() == b_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_start.size() == b_start) check({tag, " first start wait"}, 32'd0, 32'd1);
    else check({tag, " enable-to-start"}, 32'(q_start[b_start].stamp - en_stamp), 32'(PERIOD));
  endtask

  // Scoreboard: derive the expected per-scan events from the response plan.
  task automatic check_scan(input string tag, input bit chk_gap);
    int si, ti;
    logic [31:0] f;
    si = b_samp;
    ti = b_tmo;
    check({tag, " start count"}, 32'(q_start.size() - b_start), 32'(NCH));
    check({tag, " done count"}, 32'(q_done.size() - b_done), 32'd1);
    if (chk_gap && q_start.size() > b_start)
      check({tag, " idle gap"}, 32'(q_start[b_start].stamp - prev_done_stamp), 32'(PERIOD));
    for (int c = 0; c < NCH; c++) begin
      if (b_start + c < q_start.size())
        check($sformatf("%s start%0d chan", tag, c), 32'(q_start[b_start + c].chan), 32'(c));
      if (cfg_resp[c]) begin
        f = cfg_frame[c];
        m_tc  = 14'(f >> 18);
        m_jt  = 12'((f >> 4) % 4096);
        m_flt = {f[16], f[2:0]};
        if (si < q_samp.size()) begin
          check($sformatf("%s sample%0d chan", tag, c), 32'(q_samp[si].chan), 32'(c));
          check($sformatf("%s sample%0d tc", tag, c), 32'(q_samp[si].tc), 32'(m_tc));
          check($sformatf("%s sample%0d jt", tag, c), 32'(q_samp[si].jt), 32'(m_jt));
          check($sformatf("%s sample%0d flt", tag, c), 32'(q_samp[si].flt), 32'(m_flt));
          si++;
        end else check($sformatf("%s sample%0d missing", tag, c), 32'd0, 32'd1);
      end else begin
        if (ti < q_tmo.size()) begin
          check($sformatf("%s tmo%0d chan", tag, c), 32'(q_tmo[ti].chan), 32'(c));
          check($sformatf("%s tmo%0d held", tag, c),
                {2'b0, q_tmo[ti].tc, q_tmo[ti].jt, q_tmo[ti].flt}, {2'b0, m_tc, m_jt, m_flt});
          if (b_start + c < q_start.size())
            check($sformatf("%s tmo%0d latency", tag, c),
                  32'(q_tmo[ti].stamp - q_start[b_start + c].stamp), 32'(TIMEOUT + 1));
          ti++;
        end else check($sformatf("%s tmo%0d missing", tag, c), 32'd0, 32'd1);
      end
    end
    check({tag, " extra samples"}, 32'(q_samp.size() - si), 32'd0);
    check({tag, " extra timeouts"}, 32'(q_tmo.size() - ti), 32'd0);
    if (q_done.size() > b_done) begin
      check({tag, " chan_sel after done"}, 32'(q_done[b_done].chan), 32'd0);
      prev_done_stamp = q_done[b_done].stamp;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " spi_start"}, 32'(spi_start), 32'd0);
    check({tag, " chan_sel"}, 32'(chan_sel), 32'd0);
    check({tag, " sample_valid"}, 32'(sample_valid), 32'd0);
    check({tag, " sample_chan"}, 32'(sample_chan), 32'd0);
    check({tag, " tc_temp"}, 32'(tc_temp), 32'd0);
    check({tag, " junction_temp"}, 32'(junction_temp), 32'd0);
    check({tag, " fault_bits"}, 32'(fault_bits), 32'd0);
    check({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, " scan_done"}, 32'(scan_done), 32'd0);
  endtask

  initial begin
    vec_t vecs[5];
    int en_stamp, n;
    vecs[0] = '{32'hABCD_1237, 14'h2AF3, 12'h123, 4'hF};
    vecs[1] = '{32'h0000_0000, 14'h0000, 12'h000, 4'h0};
    vecs[2] = '{32'hFFFF_FFFF, 14'h3FFF, 12'hFFF, 4'hF};
    vecs[3] = '{32'h0001_0000, 14'h0000, 12'h000, 4'h8};
    vecs[4] = '{32'h8004_0010, 14'h2001, 12'h001, 4'h0};
    m_tc = '0; m_jt = '0; m_flt = '0;
    prev_done_stamp = 0;

    // Reset state
    rst = 1'b1; enable = 1'b0;
    plan(1'b0, 0, 1, 32'h0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // 1: all channels silent
    mark();
    @(negedge clk);
    enable = 1'b1;
    en_stamp = cyc;
    wait_first_start("t1", en_stamp);
    wait_done("t1");
    check_scan("t1", 1'b0);

    // 2: table of frames, every channel answers
    for (int v = 0; v < 5; v++) begin
      plan(1'b1, 1, 5, vecs[v].frame);
      mark();
      wait_done($sformatf("vec%0d", v));
      check_scan($sformatf("vec%0d", v), 1'b1);
      for (int c = 0; c < NCH; c++) begin
        if (b_samp + c < q_samp.size()) begin
          check($sformatf("vec%0d ch%0d tc", v, c), 32'(q_samp[b_samp + c].tc), 32'(vecs[v].tc));
          check($sformatf("vec%0d ch%0d jt", v, c), 32'(q_samp[b_samp + c].jt), 32'(vecs[v].jt));
          check($sformatf("vec%0d ch%0d flt", v, c), 32'(q_samp[b_samp + c].flt), 32'(vecs[v].flt));
        end
      end
    end

    // 3: channel 2 silent
    for (int c = 0; c < NCH; c++) begin
      cfg_resp[c] = (c != 2); cfg_delay[c] = 2; cfg_hold[c] = 3; cfg_frame[c] = $urandom;
    end
    mark();
    wait_done("t3");
    check_scan("t3", 1'b1);

    // 6: busy already high on entry to every start, plus latest acceptable busy rise
    plan(1'b1, 0, 2, 32'h1357_9BDF);
    cfg_delay[3] = 0;
    pre_busy = 1'b1;
    mark();
    wait_done("t6");
    pre_busy = 1'b0;
    check_scan("t6", 1'b1);
    plan(1'b1, TIMEOUT, 1, 32'h2468_ACE0);
    mark();
    wait_done("t6b");
    check_scan("t6b", 1'b1);

    // 4: enable dropped during channel 1
    plan(1'b1, 1, 4, 32'h5A5A_C3C3);
    cfg_frame[1] = 32'hDEAD_BEEF;
    mark();
    n = 0;
    while (q_start.size() < b_start + 2 && n < 500) begin @(negedge clk); n++; end
    enable = 1'b0;
    wait_done("t4");
    check_scan("t4", 1'b1);
    repeat (100) @(negedge clk);
    check("t4 no start while disabled", 32'(q_start.size() - b_start), 32'(NCH));
    mark();
    enable = 1'b1;
    en_stamp = cyc;
    wait_first_start("t4 re-enable", en_stamp);
    wait_done("t4b");
    check_scan("t4b", 1'b0);

    // 5: reset while waiting for busy to fall
    plan(1'b1, 1, 6, 32'hFFFF_FFFF);
    mark();
    n = 0;
    while (!spi_busy && n < 500) begin @(negedge clk); n++; end
    if (!spi_busy) check("t5 busy wait", 32'd0, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check_outputs_zero("t5 after reset");
    rst = 1'b0;
    m_tc = '0; m_jt = '0; m_flt = '0;
    mark();
    repeat (20) @(negedge clk);
    check("t5 no sample after reset", 32'(q_samp.size() - b_samp), 32'd0);
    check("t5 no start after reset", 32'(q_start.size() - b_start), 32'd0);
    mark();
    enable = 1'b1;
    en_stamp = cyc;
    wait_first_start("t5 re-enable", en_stamp);
    wait_done("t5b");
    check_scan("t5b", 1'b0);

    // Randomized scans against the scoreboard
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < NCH; c++) begin
        cfg_resp[c]  = 1'($urandom_range(1, 0));
        cfg_delay[c] = $urandom_range(TIMEOUT, 0);
        cfg_hold[c]  = $urandom_range(6, 1);
        cfg_frame[c] = $urandom;
      end
      mark();
      wait_done($sformatf("rnd%0d", s));
      check_scan($sformatf("rnd%0d", s), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
